// File: rtl/sram_port_arbiter_pkg.sv
// rtl/sram_port_arbiter_pkg.sv - shared encodings and widths for the unified SRAM port arbiter
package sram_port_arbiter_pkg;

    localparam int SRAM_ADDR_W = 32;
    localparam int SRAM_DATA_W = 32;
    localparam int SRAM_BE_W   = 4;
    // wide enough for MAX_WAIT up to 15
    localparam int WAIT_W      = 4;

    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_INST = 2'd1,
        OWNER_DATA = 2'd2
    } owner_e;

    typedef enum logic {
        DATA_PRI = 1'b0,
        INST_PRI = 1'b1
    } pri_state_e;

endpackage

// File: rtl/sram_port_arbiter_sat_counter.sv
// rtl/sram_port_arbiter_sat_counter.sv - saturating up-counter with clear, async active-low reset
module sat_counter #(
    parameter int           W     = 4,
    parameter logic [W-1:0] LIMIT = '1
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    // clear wins over increment
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != LIMIT)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - shares one single-port SRAM between IF fetch and MEM load/store
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int ADDR_W   = SRAM_ADDR_W,
    parameter int DATA_W   = SRAM_DATA_W,
    parameter int MAX_WAIT = 3,
    parameter int CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 inst_req,
    input  logic [ADDR_W-1:0]    inst_addr,
    output logic                 inst_gnt,
    output logic                 inst_rvalid,
    output logic [DATA_W-1:0]    inst_rdata,
    input  logic                 data_req,
    input  logic [SRAM_BE_W-1:0] data_we,
    input  logic [ADDR_W-1:0]    data_addr,
    input  logic [DATA_W-1:0]    data_wdata,
    output logic                 data_gnt,
    output logic                 data_rvalid,
    output logic [DATA_W-1:0]    data_rdata,
    output logic                 sram_en,
    output logic [SRAM_BE_W-1:0] sram_we,
    output logic [ADDR_W-1:0]    sram_addr,
    output logic [DATA_W-1:0]    sram_wdata,
    input  logic [DATA_W-1:0]    sram_rdata,
    output logic [CNT_W-1:0]     conflict_cnt
);

    pri_state_e        pri_state;
    pri_state_e        pri_next;
    owner_e            rd_owner;
    logic [WAIT_W-1:0] wait_cnt;
    logic              ireq_v;
    logic              dreq_v;
    logic              starve_hit;

    // grants are combinational, so they must be masked while reset is held
    assign ireq_v     = inst_req & resetn;
    assign dreq_v     = data_req & resetn;
    assign starve_hit = (wait_cnt == WAIT_W'(MAX_WAIT - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pri_state <= DATA_PRI;
        end else begin
            pri_state <= pri_next;
        end
    end

    always_comb begin
        pri_next = pri_state;
        inst_gnt = 1'b0;
        data_gnt = 1'b0;
        case (pri_state)
            DATA_PRI: begin
                data_gnt = dreq_v;
                inst_gnt = ireq_v && !dreq_v;
                if (ireq_v && dreq_v && starve_hit) begin
                    pri_next = INST_PRI;
                end
            end
            INST_PRI: begin
                inst_gnt = ireq_v;
                data_gnt = dreq_v && !ireq_v;
                pri_next = DATA_PRI;
            end
            default: pri_next = DATA_PRI;
        endcase
    end

    always_comb begin
        sram_en    = inst_gnt | data_gnt;
        sram_we    = '0;
        sram_addr  = '0;
        sram_wdata = '0;
        if (data_gnt) begin
            sram_we    = data_we;
            sram_addr  = data_addr;
            sram_wdata = data_wdata;
        end else if (inst_gnt) begin
            sram_addr  = inst_addr;
        end
    end

    // writes produce no response, so they leave the owner at NONE
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_owner <= OWNER_NONE;
        end else if (inst_gnt) begin
            rd_owner <= OWNER_INST;
        end else if (data_gnt && (data_we == '0)) begin
            rd_owner <= OWNER_DATA;
        end else begin
            rd_owner <= OWNER_NONE;
        end
    end

    assign inst_rvalid = (rd_owner == OWNER_INST);
    assign data_rvalid = (rd_owner == OWNER_DATA);
    assign inst_rdata  = inst_rvalid ? sram_rdata : '0;
    assign data_rdata  = data_rvalid ? sram_rdata : '0;

    sat_counter #(
        .W     (WAIT_W),
        .LIMIT (WAIT_W'(MAX_WAIT))
    ) u_wait_cnt (
        .clk    (clk),
        .resetn (resetn),
        .inc    (ireq_v && !inst_gnt),
        .clr    (inst_gnt || !ireq_v),
        .count  (wait_cnt)
    );

    sat_counter #(
        .W     (CNT_W),
        .LIMIT ('1)
    ) u_conflict_cnt (
        .clk    (clk),
        .resetn (resetn),
        .inc    (ireq_v && dreq_v),
        .clr    (1'b0),
        .count  (conflict_cnt)
    );

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - scoreboard bench for sram_port_arbiter
module tb_sram_port_arbiter;
    import sram_port_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_gnt;
    logic        inst_rvalid;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic [3:0]  data_we;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_gnt;
    logic        data_rvalid;
    logic [31:0] data_rdata;
    logic        sram_en;
    logic [3:0]  sram_we;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;
    logic [3:0]  conflict_cnt;

    int          n_total = 0;
    int          n_bad   = 0;
    logic [1:0]  exp_q[$];
    int          exp_conf;

    always #5 clk = ~clk;

    sram_port_arbiter #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .MAX_WAIT (3),
        .CNT_W    (4)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_gnt     (inst_gnt),
        .inst_rvalid  (inst_rvalid),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_we      (data_we),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_gnt     (data_gnt),
        .data_rvalid  (data_rvalid),
        .data_rdata   (data_rdata),
        .sram_en      (sram_en),
        .sram_we      (sram_we),
        .sram_addr    (sram_addr),
        .sram_wdata   (sram_wdata),
        .sram_rdata   (sram_rdata),
        .conflict_cnt (conflict_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // one clock cycle: drive at posedge+1, check at negedge, return at next posedge+1
    task automatic cyc(input logic ir, input logic [31:0] ia, input logic dr,
                       input logic [3:0] dwe, input logic [31:0] da, input logic [31:0] dwd,
                       input logic [31:0] rdv, input logic eig, input logic edg,
                       input logic rst_mid);
        logic [1:0] own;
        inst_req   = ir;
        inst_addr  = ia;
        data_req   = dr;
        data_we    = dwe;
        data_addr  = da;
        data_wdata = dwd;
        sram_rdata = rdv;
        #4;
        own = OWNER_NONE;
        if (exp_q.size() == 0) chk("sb_empty", 32'd1, 32'd0);
        else own = exp_q.pop_front();
        chk("inst_rvalid", 32'(inst_rvalid), 32'(own == OWNER_INST));
        chk("data_rvalid", 32'(data_rvalid), 32'(own == OWNER_DATA));
        chk("inst_rdata", inst_rdata, (own == OWNER_INST) ? rdv : 32'h0);
        chk("data_rdata", data_rdata, (own == OWNER_DATA) ? rdv : 32'h0);
        chk("inst_gnt", 32'(inst_gnt), 32'(eig));
        chk("data_gnt", 32'(data_gnt), 32'(edg));
        chk("sram_en", 32'(sram_en), 32'(eig | edg));
        chk("sram_addr", sram_addr, edg ? da : (eig ? ia : 32'h0));
        chk("sram_we", 32'(sram_we), edg ? 32'(dwe) : 32'h0);
        chk("sram_wdata", sram_wdata, edg ? dwd : 32'h0);
        chk("conflict_cnt", 32'(conflict_cnt), 32'(exp_conf));
        if (eig) exp_q.push_back(OWNER_INST);
        else if (edg && dwe == 4'h0) exp_q.push_back(OWNER_DATA);
        else exp_q.push_back(OWNER_NONE);
        if (ir && dr && exp_conf != 15) exp_conf++;
        if (rst_mid) begin
            #1 resetn = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0, 0, $urandom, 0, 0, 0);
    endtask

    initial begin
        resetn = 1'b0;
        inst_req = 0; inst_addr = 0; data_req = 0; data_we = 0;
        data_addr = 0; data_wdata = 0; sram_rdata = 0;
        exp_conf = 0;
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        exp_q.push_back(OWNER_NONE);
        idle(1);

        // inst-only fetch stream, responses A/B/C one cycle behind each grant
        cyc(1, 32'h1C00_0000, 0, 0, 0, 0, $urandom, 1, 0, 0);
        cyc(1, 32'h1C00_0000, 0, 0, 0, 0, 32'hA, 1, 0, 0);
        cyc(1, 32'h1C00_0000, 0, 0, 0, 0, 32'hB, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 32'hC, 0, 0, 0);

        // collision under data priority
        cyc(1, 32'h1C00_0004, 1, 0, 32'h100, 0, $urandom, 0, 1, 0);
        idle(1);

        // starvation: inst forced through on the fourth cycle
        for (int i = 0; i < 6; i++)
            cyc(1, 32'h1C00_0008, 1, 0, 32'h300, 0, $urandom, i == 3, i != 3, 0);
        idle(1);

        // byte-strobed store, no response
        cyc(0, 0, 1, 4'b0011, 32'h200, 32'hDEAD_BEEF, $urandom, 0, 1, 0);
        idle(1);

        // conflict counter saturation
        for (int i = 0; i < 20; i++)
            cyc(1, 32'h1C00_0010, 1, 0, 32'h400, 0, $urandom, (i % 4) == 3, (i % 4) != 3, 0);
        idle(1);

        // reset while an inst read is in flight
        cyc(1, 32'h1C00_0020, 1, 0, 32'h500, 0, $urandom, 0, 1, 0);
        cyc(1, 32'h1C00_0020, 0, 0, 0, 0, $urandom, 1, 0, 1);
        data_req = 1'b1;
        #3;
        chk("rst_inst_gnt", 32'(inst_gnt), 32'h0);
        chk("rst_data_gnt", 32'(data_gnt), 32'h0);
        chk("rst_sram_en", 32'(sram_en), 32'h0);
        chk("rst_inst_rvalid", 32'(inst_rvalid), 32'h0);
        chk("rst_data_rvalid", 32'(data_rvalid), 32'h0);
        chk("rst_conflict", 32'(conflict_cnt), 32'h0);
        chk("rst_wait_cnt", 32'(dut.wait_cnt), 32'h0);
        @(posedge clk);
        #1;
        inst_req = 0; data_req = 0;
        resetn = 1'b1;
        exp_q.delete();
        exp_q.push_back(OWNER_NONE);
        exp_conf = 0;
        idle(2);
        chk("post_wait_cnt", 32'(dut.wait_cnt), 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
